wb_prog_loader: RTL

//  Wishbone classic slave between the management SoC bus and the RISC-V core. Firmware holds
//  the core in reset, pushes program words into a FIFO, and the block streams them as
//  {addr,data} writes into the core's program memory. Writing CTRL.HOLD=0 then releases the core.

---
 rtl/wb_prog_loader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/wb_prog_loader.sv
// Wishbone classic slave that queues program words in a FIFO and streams them as
// {addr,data} writes into the core's program memory, and controls the core's reset.
module wb_prog_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          DEPTH     = 8,
   parameter int          AW        = 16
) (
   input  logic          wb_clk_i,
   input  logic          rst_n,
   input  logic          wbs_cyc_i,
   input  logic          wbs_stb_i,
   input  logic          wbs_we_i,
   input  logic [3:0]    wbs_sel_i,
   input  logic [31:0]   wbs_adr_i,
   input  logic [31:0]   wbs_dat_i,
   output logic          wbs_ack_o,
   output logic [31:0]   wbs_dat_o,
   output logic          mem_wr_valid,
   input  logic          mem_wr_ready,
   output logic [AW-1:0] mem_wr_addr,
   output logic [31:0]   mem_wr_data,
   output logic          core_rst_n
);
   localparam int PW = $clog2(DEPTH);

   logic          ack_q, ack_d;
   logic [31:0]   rdat_q, rdat_d;
   logic [PW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          hold_q, hold_d, ovf_q, ovf_d, err_q, err_d;
   logic          core_rst_q, core_rst_d;
   logic          we_q;
   logic [1:0]    reg_q;
   logic [31:0]   wdat_q;
   logic [31:0]   fifo_q [DEPTH];

   logic          access, empty, full, push, pop, flush;
   logic          wr_ctrl, wr_stat, wr_data, wr_addr;
   logic [PW:0]   count;
   logic [7:0]    cnt8;
   logic [31:0]   status;
   logic          unused_ok;

   assign access  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~ack_q;
   assign count   = wptr_q - rptr_q;
   assign cnt8    = 8'(count);
   assign empty   = (count == '0);
   assign full    = (count == (PW+1)'(DEPTH));
   assign status  = {14'b0, err_q, ovf_q, 6'b0, empty, full, cnt8};

   // Register side effects are applied in the ack cycle from the request latched at access.
   assign wr_ctrl = ack_q & we_q & (reg_q == 2'd0);
   assign wr_stat = ack_q & we_q & (reg_q == 2'd1);
   assign wr_data = ack_q & we_q & (reg_q == 2'd2);
   assign wr_addr = ack_q & we_q & (reg_q == 2'd3);
   assign flush   = wr_ctrl & wdat_q[1];
   assign push    = wr_data & ~full;
   assign pop     = ~empty & mem_wr_ready & ~flush;

   always_comb begin
      ack_d  = access;
      rdat_d = '0;
      if (access && !wbs_we_i) begin
         case (wbs_adr_i[3:2])
            2'd0:    rdat_d = {31'b0, hold_q};
            2'd1:    rdat_d = status;
            2'd2:    rdat_d = '0;
            default: rdat_d = 32'(addr_q);
         endcase
      end
      wptr_d = wptr_q + {{PW{1'b0}}, push};
      rptr_d = flush ? wptr_q : rptr_q + {{PW{1'b0}}, pop};
      addr_d = addr_q;
      if (pop)
         addr_d = addr_q + AW'(4);
      else if (wr_addr && empty)
         addr_d = {wdat_q[AW-1:2], 2'b00};
      ovf_d = ovf_q;
      if (wr_data && full)
         ovf_d = 1'b1;
      else if (wr_stat && wdat_q[16])
         ovf_d = 1'b0;
      err_d = err_q;
      if (wr_addr && !empty)
         err_d = 1'b1;
      else if (wr_stat && wdat_q[17])
         err_d = 1'b0;
      hold_d     = wr_ctrl ? wdat_q[0] : hold_q;
      core_rst_d = ~hold_d;
   end

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         ack_q      <= 1'b0;
         rdat_q     <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         addr_q     <= '0;
         hold_q     <= 1'b1;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
         core_rst_q <= 1'b0;
      end else begin
         ack_q      <= ack_d;
         rdat_q     <= rdat_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         addr_q     <= addr_d;
         hold_q     <= hold_d;
         ovf_q      <= ovf_d;
         err_q      <= err_d;
         core_rst_q <= core_rst_d;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (access) begin
         we_q   <= wbs_we_i;
         reg_q  <= wbs_adr_i[3:2];
         wdat_q <= wbs_dat_i;
      end
      if (push)
         fifo_q[wptr_q[PW-1:0]] <= wdat_q;
   end

   assign wbs_ack_o    = ack_q;
   assign wbs_dat_o    = rdat_q;
   assign mem_wr_valid = ~empty;
   assign mem_wr_addr  = addr_q;
   assign mem_wr_data  = fifo_q[rptr_q[PW-1:0]];
   assign core_rst_n   = core_rst_q;
   assign unused_ok    = ^{wbs_sel_i, wbs_adr_i[1:0]};
endmodule
